// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed reads returned after a fixed
// wait-state latency, plus an independent ISP write port into the same store.
module imem_responder #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int OFFSET_BITS  = 3,
  parameter int ADDRESS_BITS = 20,
  parameter int MEM_BITS     = 10,
  parameter int LATENCY      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDRESS_BITS-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDRESS_BITS-1:0] read_address,
  output logic [ADDRESS_BITS-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    valid,
  output logic                    ready,
  input  logic                    report
);

  // state | meaning
  // IDLE  | ready high, waiting for read
  // WAIT  | request in flight, counter running down to 1
  // RESP  | one-cycle valid pulse with the latched word

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("imem_responder: LATENCY must be in 1..15");
  end
  if (MEM_BITS > ADDRESS_BITS) begin : g_mem_bits_check
    $error("imem_responder: MEM_BITS must not exceed ADDRESS_BITS");
  end

  state_t                  state, next_state;
  logic [3:0]              counter, next_counter;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   mem [2**MEM_BITS];
  logic [MEM_BITS-1:0]     rd_idx;
  logic [MEM_BITS-1:0]     wr_idx;
  logic                    accept;
  logic                    unused_ok;

  assign rd_idx = read_address[MEM_BITS-1:0];
  assign wr_idx = write_address[MEM_BITS-1:0];
  assign ready  = (state == IDLE) && !reset;
  assign valid  = (state == RESP);
  assign accept = read && ready;

  // Upper address bits alias; the remaining inputs/parameters are informational.
  assign unused_ok = ^{report, write_address, read_address,
                       32'(CORE + INDEX_BITS + OFFSET_BITS)};

  // Storage survives reset; ISP writes are never blocked.
  always_ff @(posedge clock) begin
    if (write) mem[wr_idx] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  always_comb begin
    next_state   = state;
    next_counter = counter;
    case (state)
      IDLE: begin
        if (accept) begin
          next_counter = 4'(LATENCY - 1);
          next_state   = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        next_counter = counter - 4'd1;
        if (counter == 4'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Nonblocking read of mem gives the pre-edge word on a same-edge ISP write.
  // With LATENCY==1 the response loads straight from the request path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        addr_q <= read_address;
        data_q <= mem[rd_idx];
      end
      if (state == IDLE && next_state == RESP) begin
        out_addr <= read_address;
        out_data <= mem[rd_idx];
      end else if (state == WAIT && next_state == RESP) begin
        out_addr <= addr_q;
        out_data <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 2, 3, 1) share stimulus and
// are checked every cycle against a cycle-count/array reference model.
module tb_imem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [19:0] write_address = '0;
  logic [31:0] in_data = '0;
  logic [19:0] read_address = '0;
  logic        report = 1'b0;

  logic [2:0][19:0] oa;
  logic [2:0][31:0] od;
  logic [2:0]       vld;
  logic [2:0]       rdy;

  int n_checks = 0;
  int n_fail   = 0;
  int lat [3] = '{2, 3, 1};

  always #5 clock = ~clock;

  imem_responder #(.CORE(0), .DATA_WIDTH(32), .INDEX_BITS(6), .OFFSET_BITS(3),
                   .ADDRESS_BITS(20), .MEM_BITS(10), .LATENCY(2)) u0 (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .write_address(write_address), .in_data(in_data), .read_address(read_address),
    .out_addr(oa[0]), .out_data(od[0]), .valid(vld[0]), .ready(rdy[0]), .report(report));

  imem_responder #(.CORE(1), .DATA_WIDTH(32), .INDEX_BITS(6), .OFFSET_BITS(3),
                   .ADDRESS_BITS(20), .MEM_BITS(10), .LATENCY(3)) u1 (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .write_address(write_address), .in_data(in_data), .read_address(read_address),
    .out_addr(oa[1]), .out_data(od[1]), .valid(vld[1]), .ready(rdy[1]), .report(report));

  imem_responder #(.CORE(2), .DATA_WIDTH(32), .INDEX_BITS(6), .OFFSET_BITS(3),
                   .ADDRESS_BITS(20), .MEM_BITS(10), .LATENCY(1)) u2 (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .write_address(write_address), .in_data(in_data), .read_address(read_address),
    .out_addr(oa[2]), .out_data(od[2]), .valid(vld[2]), .ready(rdy[2]), .report(report));

  // Reference model: k is the index of the next rising edge. A request taken at
  // edge e is reported before edge e+L, and the responder is free again at e+L+1.
  bit [31:0] mem_m [1024];
  longint    k = 0;
  bit        pend [3];
  longint    resp_at [3];
  longint    free_at [3];
  bit [19:0] r_addr [3];
  bit [31:0] r_data [3];
  bit [19:0] last_addr [3];
  bit [31:0] last_data [3];
  bit        ev, er;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        pend[i]      = 1'b0;
        last_addr[i] = '0;
        last_data[i] = '0;
        free_at[i]   = k + 1;
      end
      ev = !reset && pend[i] && (resp_at[i] == k);
      if (ev) begin
        last_addr[i] = r_addr[i];
        last_data[i] = r_data[i];
        pend[i]      = 1'b0;
      end
      er = !reset && (k >= free_at[i]);
      n_checks += 4;
      if (vld[i] !== ev) begin
        n_fail++;
        $display("FAIL mon_valid[%0d] edge=%0d got %b expected %b", i, k, vld[i], ev);
      end
      if (rdy[i] !== er) begin
        n_fail++;
        $display("FAIL mon_ready[%0d] edge=%0d got %b expected %b", i, k, rdy[i], er);
      end
      if (oa[i] !== last_addr[i]) begin
        n_fail++;
        $display("FAIL mon_out_addr[%0d] edge=%0d got %h expected %h", i, k, oa[i], last_addr[i]);
      end
      if (od[i] !== last_data[i]) begin
        n_fail++;
        $display("FAIL mon_out_data[%0d] edge=%0d got %h expected %h", i, k, od[i], last_data[i]);
      end
      if (!reset && read && er) begin
        pend[i]    = 1'b1;
        resp_at[i] = k + lat[i];
        free_at[i] = k + lat[i] + 1;
        r_addr[i]  = read_address;
        r_data[i]  = mem_m[read_address[9:0]];
      end
    end
    if (write) mem_m[write_address[9:0]] = in_data;
    k++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    read  = 1'b0;
    write = 1'b0;
    repeat (6) tick();
  endtask

  task automatic preload();
    for (int a = 0; a < 1024; a++) begin
      write         = 1'b1;
      write_address = 20'(a);
      in_data       = $urandom;
      tick();
    end
    write = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdy[i] !== 1'b0 || vld[i] !== 1'b0 || oa[i] !== 20'd0 || od[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d] got rdy=%b vld=%b addr=%h data=%h expected 0 0 0 0",
                 i, rdy[i], vld[i], oa[i], od[i]);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rdy[i] !== 1'b1 || vld[i] !== 1'b0 || oa[i] !== 20'd0 || od[i] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_release[%0d] got rdy=%b vld=%b addr=%h data=%h expected 1 0 0 0",
                   i, rdy[i], vld[i], oa[i], od[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_basic_read();
    write = 1'b1; write_address = 20'h5; in_data = 32'hDEADBEEF;
    tick();
    write = 1'b0;
    read = 1'b1; read_address = 20'h5;
    tick();
    read = 1'b0;
    n_checks++;
    if (rdy[0] !== 1'b0 || vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_t1 got rdy=%b vld=%b expected 0 0", rdy[0], vld[0]);
    end
    tick();
    n_checks++;
    if (vld[0] !== 1'b1 || rdy[0] !== 1'b0 || oa[0] !== 20'h5 || od[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_t2 got vld=%b rdy=%b addr=%h data=%h expected 1 0 00005 deadbeef",
               vld[0], rdy[0], oa[0], od[0]);
    end
    tick();
    n_checks++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1 || oa[0] !== 20'h5 || od[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_t3 got vld=%b rdy=%b addr=%h data=%h expected 0 1 00005 deadbeef",
               vld[0], rdy[0], oa[0], od[0]);
    end
    drain();
  endtask

  task automatic test_same_edge();
    write = 1'b1; write_address = 20'h7; in_data = 32'h22222222;
    tick();
    in_data = 32'h11111111;
    read = 1'b1; read_address = 20'h7;
    tick();
    read = 1'b0; write = 1'b0;
    tick();
    n_checks++;
    if (vld[0] !== 1'b1 || od[0] !== 32'h22222222) begin
      n_fail++;
      $display("FAIL same_edge_old got vld=%b data=%h expected 1 22222222", vld[0], od[0]);
    end
    drain();
    read = 1'b1; read_address = 20'h7;
    tick();
    read = 1'b0;
    tick();
    n_checks++;
    if (vld[0] !== 1'b1 || od[0] !== 32'h11111111) begin
      n_fail++;
      $display("FAIL same_edge_new got vld=%b data=%h expected 1 11111111", vld[0], od[0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [19:0] base;
    int t;
    bit  exp_v;
    base = 20'($urandom_range(1, 20'hFFF00));
    for (int j = 0; j < 40; j++) begin
      read = 1'b1;
      read_address = 20'(base + 20'(j));
      tick();
      for (int i = 0; i < 3; i++) begin
        t = j + 1 - lat[i];
        exp_v = (t >= 0) && (t % (lat[i] + 1) == 0);
        n_checks++;
        if (vld[i] !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_valid[%0d] cycle=%0d got %b expected %b", i, j, vld[i], exp_v);
        end else if (exp_v && oa[i] !== 20'(base + 20'(t))) begin
          n_fail++;
          $display("FAIL b2b_order[%0d] cycle=%0d got %h expected %h", i, j, oa[i], 20'(base + 20'(t)));
        end
      end
    end
    drain();
  endtask

  task automatic test_abort_reset();
    read = 1'b1; read_address = 20'h3;
    tick();
    read  = 1'b0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (vld[i] !== 1'b0 || rdy[i] !== 1'b0 || oa[i] !== 20'd0 || od[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL abort_clear[%0d] got vld=%b rdy=%b addr=%h data=%h expected 0 0 0 0",
                 i, vld[i], rdy[i], oa[i], od[i]);
      end
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (vld[i] !== 1'b0 || rdy[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL abort_no_valid[%0d] cycle=%0d got vld=%b rdy=%b expected 0 1",
                   i, c, vld[i], rdy[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_alias();
    write = 1'b1; write_address = 20'h00400; in_data = 32'hAAAA0001;
    tick();
    write = 1'b0;
    read = 1'b1; read_address = 20'h00000;
    tick();
    read = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == c) begin
          n_checks++;
          if (vld[i] !== 1'b1 || oa[i] !== 20'h0 || od[i] !== 32'hAAAA0001) begin
            n_fail++;
            $display("FAIL alias[%0d] got vld=%b addr=%h data=%h expected 1 00000 aaaa0001",
                     i, vld[i], oa[i], od[i]);
          end
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 49) == 0);
      read          = ($urandom_range(0, 3) != 0);
      write         = $urandom_range(0, 1) == 1;
      read_address  = {10'($urandom), 6'd0, 4'($urandom)};
      write_address = {10'($urandom), 6'd0, 4'($urandom)};
      in_data       = $urandom;
      tick();
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    tick();
    preload();
    test_reset();
    test_basic_read();
    test_same_edge();
    test_back_to_back();
    test_abort_reset();
    test_alias();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the instruction-fetch read interface: accepts word-addressed read requests and returns data after a fixed, parameterised wait-state latency.
- Accepts In-System Programmer (ISP) word writes on an independent port.
- Sits behind the fetch path as the backing instruction store; also used as a wait-state model so fetch can be verified against a slow memory.

Parameters:
- CORE, 0, core index; carried for reporting only.
- DATA_WIDTH, 32, word width in bits.
- INDEX_BITS, 6, carried for interface compatibility; unused.
- OFFSET_BITS, 3, carried for interface compatibility; unused.
- ADDRESS_BITS, 20, width of word addresses on all address ports.
- MEM_BITS, 10, log2 of storage depth in words; must satisfy MEM_BITS <= ADDRESS_BITS.
- LATENCY, 2, cycles from request acceptance to valid; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- read  input  1  read request; qualified by ready.
- write  input  1  ISP write strobe.
- write_address  input  ADDRESS_BITS  ISP word address.
- in_data  input  DATA_WIDTH  ISP write data.
- read_address  input  ADDRESS_BITS  requested word address.
- out_addr  output  ADDRESS_BITS  word address of the returned data.
- out_data  output  DATA_WIDTH  returned word.
- valid  output  1  one-cycle pulse: out_addr/out_data are valid.
- ready  output  1  responder can accept a read this cycle.
- report  input  1  debug-print enable; no functional effect.

Behaviour:
- Storage: 2^MEM_BITS words, indexed by address[MEM_BITS-1:0]; upper address bits ignored, so addresses alias.
- Storage contents are not cleared by reset.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, counter=0, valid=0, out_addr=0, out_data=0, ready=0.
  - ready is combinational: (state==IDLE) and not reset. It therefore rises in the first cycle after reset deasserts.
- ISP write: on any edge with write=1, mem[write_address] <= in_data. Writes are accepted in every state; there is no back-pressure on writes.
- Request acceptance: read && ready at a rising edge.
  - Latch addr_q <= read_address.
  - Latch data_q <= mem[read_address], reading the contents as they stood before that edge (read-before-write).
  - A same-edge ISP write to the same address returns the old word.
- State machine:
  - IDLE: on acceptance, counter <= LATENCY-1. Go to RESP if LATENCY==1, otherwise go to WAIT.
  - WAIT: counter decrements each cycle. When counter==1, go to RESP at the next edge. ready=0 throughout.
  - RESP (exactly 1 cycle): valid=1, out_addr=addr_q, out_data=data_q, ready=0. Then go to IDLE.
- Outputs hold their last values when valid=0, with two exceptions: reset clears them, and a new RESP overwrites them.
- Latency: valid is asserted exactly LATENCY cycles after the acceptance edge.
- Throughput: one request per LATENCY+1 cycles, because the IDLE acceptance cycle is required.
- read while ready=0 is ignored; it is not queued. The requester must hold read until ready is sampled high.
- ISP writes during WAIT do not alter the in-flight data_q.
- Reset asserted during WAIT or RESP aborts the request. No valid pulse is produced for it, and outputs clear immediately.
- Counter width is 4 bits; LATENCY outside 1..15 is a configuration error, flagged by a simulation-only check.

Test Plan:
- Reset release, LATENCY=2: after reset drops, ready=1, valid=0, out_addr=0, out_data=0 -> all hold until the first request.
- ISP write mem[0x5]=0xDEADBEEF, then read 0x5 accepted at edge T -> valid=1 at T+2 with out_addr=0x5, out_data=0xDEADBEEF; ready=0 at T+1 and T+2, ready=1 at T+3.
- Same-edge write 0x11111111 and read to address 0x7 holding 0x22222222 -> response 0x22222222; a following read of 0x7 returns 0x11111111.
- read held high continuously, LATENCY=3 -> exactly one valid per 4 cycles; addresses returned in request order; no duplicated or dropped pulses.
- Reset asserted one cycle after accepting a read of 0x3 -> valid never pulses for it; outputs read 0 immediately; ready=1 the cycle after reset falls.
- Aliasing, MEM_BITS=10: write 0x00400 = 0xAAAA0001, read 0x00000 -> out_data=0xAAAA0001, out_addr=0x00000. Repeat with LATENCY=1 -> valid one cycle after acceptance.
